// File: rtl/lsu_ctrl_pkg.sv
// Shared load/store definitions: memory opcodes, funct3 access-size codes,
// controller state encoding and small decode helpers used by the LSU.
package lsu_ctrl_pkg;

  // Memory operation class from the decoder. Code 2'b11 is unused and
  // behaves like a NOP.
  localparam logic [1:0] MEM_OP_NOP   = 2'b00;
  localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
  localparam logic [1:0] MEM_OP_STORE = 2'b10;

  // Access size/sign, funct3 encoding.
  localparam logic [2:0] MEM_SEL_B  = 3'b000;
  localparam logic [2:0] MEM_SEL_H  = 3'b001;
  localparam logic [2:0] MEM_SEL_W  = 3'b010;
  localparam logic [2:0] MEM_SEL_BU = 3'b100;
  localparam logic [2:0] MEM_SEL_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT1 = 2'd1,
    ST_BEAT2 = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // Access size in bytes. Illegal codes return 4; they never reach the bus.
  function automatic logic [2:0] sel_size(input logic [2:0] sel);
    case (sel)
      MEM_SEL_B, MEM_SEL_BU: sel_size = 3'd1;
      MEM_SEL_H, MEM_SEL_HU: sel_size = 3'd2;
      default:               sel_size = 3'd4;
    endcase
  endfunction

  // Byte mask of the access before lane shifting: 2^size - 1.
  function automatic logic [3:0] sel_mask(input logic [2:0] sel);
    case (sel_size(sel))
      3'd1:    sel_mask = 4'b0001;
      3'd2:    sel_mask = 4'b0011;
      default: sel_mask = 4'b1111;
    endcase
  endfunction

  // Loads take all five codes, stores only the unsigned-agnostic three.
  function automatic logic sel_legal(input logic is_store, input logic [2:0] sel);
    case (sel)
      MEM_SEL_B, MEM_SEL_H, MEM_SEL_W: sel_legal = 1'b1;
      MEM_SEL_BU, MEM_SEL_HU:          sel_legal = !is_store;
      default:                         sel_legal = 1'b0;
    endcase
  endfunction

  // Access crosses a word boundary when off + size > 4.
  function automatic logic is_split(input logic [1:0] off, input logic [2:0] sel);
    is_split = ({2'b00, off} + {1'b0, sel_size(sel)}) > 4'd4;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the LSU (purely combinational).
//   off, sel   : byte offset within the word and funct3 size code
//   wdata      : right-aligned store data
//   lo, hi     : read data captured from beat 1 / beat 2
//   be64       : byte enables across two words (low nibble = beat 1)
//   wd64       : lane-shifted store data across two words
//   ldata      : loaded value, shifted down and sign/zero extended
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  sel,
  input  logic [31:0] wdata,
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  output logic [7:0]  be64,
  output logic [63:0] wd64,
  output logic [31:0] ldata
);

  logic [63:0] rd64;

  always_comb begin
    be64  = {4'b0000, sel_mask(sel)} << off;
    wd64  = {32'b0, wdata} << {off, 3'b000};
    rd64  = {hi, lo} >> {off, 3'b000};
    ldata = '0;
    case (sel)
      MEM_SEL_B:  ldata = {{24{rd64[7]}}, rd64[7:0]};
      MEM_SEL_H:  ldata = {{16{rd64[15]}}, rd64[15:0]};
      MEM_SEL_W:  ldata = rd64[31:0];
      MEM_SEL_BU: ldata = {24'b0, rd64[7:0]};
      MEM_SEL_HU: ldata = {16'b0, rd64[15:0]};
      default:    ldata = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencing controller. Accepts one decoded memory request at a
// time, issues one or two word-aligned bus beats (misaligned accesses are
// split across two words), then returns extended load data or store
// completion for one cycle. The pipeline is stalled while busy.
//   req_*/mem_op/mem_sel/addr/wdata/rd : request from execute
//   busy                               : stall, == !req_ready
//   resp_*                             : one-cycle completion to writeback
//   bus_*                              : registered data-memory bus master
// TIMEOUT_CYCLES: cycles a beat may wait for bus_ack (0 = never time out).
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  mem_op,
  input  logic [2:0]  mem_sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic       TMO_EN   = (TIMEOUT_CYCLES != 0);

  lsu_state_e state, state_n;

  // Registered request fields.
  logic        q_store, q_store_n;
  logic [2:0]  q_sel, q_sel_n;
  logic [1:0]  q_off, q_off_n;
  logic [31:0] q_wdata, q_wdata_n;
  logic [4:0]  q_rd, q_rd_n;
  logic        q_split, q_split_n;

  // Captured read data, error flag, per-beat wait counter.
  logic [31:0] lo, lo_n, hi, hi_n;
  logic        err, err_n;
  logic [7:0]  cnt, cnt_n;

  logic        bus_req_n, bus_we_n;
  logic [31:0] bus_addr_n, bus_wdata_n;
  logic [3:0]  bus_be_n;

  // One aligner serves both beats: in IDLE it sees the incoming request so
  // beat 1 can be registered at acceptance; afterwards it sees the held copy.
  logic [1:0]  al_off;
  logic [2:0]  al_sel;
  logic [31:0] al_wdata, al_ldata;
  logic [7:0]  al_be64;
  logic [63:0] al_wd64;

  logic in_idle, is_mem, is_store, tmo_hit;

  assign in_idle  = (state == ST_IDLE);
  assign is_mem   = (mem_op == MEM_OP_LOAD) || (mem_op == MEM_OP_STORE);
  assign is_store = (mem_op == MEM_OP_STORE);
  assign tmo_hit  = TMO_EN && (cnt == TMO_LAST);

  assign al_off   = in_idle ? addr[1:0] : q_off;
  assign al_sel   = in_idle ? mem_sel   : q_sel;
  assign al_wdata = in_idle ? wdata     : q_wdata;

  lsu_align u_align (
    .off   (al_off),
    .sel   (al_sel),
    .wdata (al_wdata),
    .lo    (lo),
    .hi    (hi),
    .be64  (al_be64),
    .wd64  (al_wd64),
    .ldata (al_ldata)
  );

  assign req_ready  = in_idle && !rst;
  assign busy       = !req_ready;
  assign resp_valid = (state == ST_RESP);
  assign resp_err   = resp_valid && err;
  assign resp_rdata = (resp_valid && !q_store && !err) ? al_ldata : '0;
  assign resp_rd    = (resp_valid && !q_store) ? q_rd : '0;

  always_comb begin
    state_n     = state;
    q_store_n   = q_store;
    q_sel_n     = q_sel;
    q_off_n     = q_off;
    q_wdata_n   = q_wdata;
    q_rd_n      = q_rd;
    q_split_n   = q_split;
    lo_n        = lo;
    hi_n        = hi;
    err_n       = err;
    cnt_n       = cnt;
    bus_req_n   = bus_req;
    bus_we_n    = bus_we;
    bus_addr_n  = bus_addr;
    bus_be_n    = bus_be;
    bus_wdata_n = bus_wdata;

    case (state)
      ST_IDLE: begin
        if (req_valid && is_mem) begin
          q_store_n = is_store;
          q_sel_n   = mem_sel;
          q_off_n   = addr[1:0];
          q_wdata_n = wdata;
          q_rd_n    = rd;
          q_split_n = is_split(addr[1:0], mem_sel);
          lo_n      = '0;
          hi_n      = '0;
          cnt_n     = '0;
          if (!sel_legal(is_store, mem_sel)) begin
            err_n   = 1'b1;
            state_n = ST_RESP;
          end else begin
            err_n       = 1'b0;
            state_n     = ST_BEAT1;
            bus_req_n   = 1'b1;
            bus_we_n    = is_store;
            bus_addr_n  = {addr[31:2], 2'b00};
            bus_be_n    = al_be64[3:0];
            bus_wdata_n = al_wd64[31:0];
          end
        end
      end

      ST_BEAT1, ST_BEAT2: begin
        if (bus_ack) begin
          cnt_n = '0;
          if (state == ST_BEAT1) lo_n = bus_rdata;
          else                   hi_n = bus_rdata;
          if (state == ST_BEAT1 && q_split) begin
            // Second beat follows back-to-back; bus_req stays high.
            state_n     = ST_BEAT2;
            bus_addr_n  = bus_addr + 32'd4;
            bus_be_n    = al_be64[7:4];
            bus_wdata_n = al_wd64[63:32];
          end else begin
            state_n = ST_RESP;
          end
        end else if (tmo_hit) begin
          // Abandon the beat; a completed first store beat is not undone.
          err_n   = 1'b1;
          state_n = ST_RESP;
        end else begin
          cnt_n = cnt + 8'd1;
        end
        if (state_n == ST_RESP) begin
          bus_req_n   = 1'b0;
          bus_we_n    = 1'b0;
          bus_addr_n  = '0;
          bus_be_n    = '0;
          bus_wdata_n = '0;
        end
      end

      ST_RESP: state_n = ST_IDLE;

      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      q_store   <= 1'b0;
      q_sel     <= '0;
      q_off     <= '0;
      q_wdata   <= '0;
      q_rd      <= '0;
      q_split   <= 1'b0;
      lo        <= '0;
      hi        <= '0;
      err       <= 1'b0;
      cnt       <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
    end else begin
      state     <= state_n;
      q_store   <= q_store_n;
      q_sel     <= q_sel_n;
      q_off     <= q_off_n;
      q_wdata   <= q_wdata_n;
      q_rd      <= q_rd_n;
      q_split   <= q_split_n;
      lo        <= lo_n;
      hi        <= hi_n;
      err       <= err_n;
      cnt       <= cnt_n;
      bus_req   <= bus_req_n;
      bus_we    <= bus_we_n;
      bus_addr  <= bus_addr_n;
      bus_be    <= bus_be_n;
      bus_wdata <= bus_wdata_n;
    end
  end

endmodule
